// File: rtl/mem_sequencer.sv
// mem_sequencer: loads a run of operand pairs into the dual-bank memory stage and replays them as mirrored reads
module mem_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] load_len,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic       mem_rw,
  output logic [3:0] mem_addr_a,
  output logic [3:0] mem_addr_b,
  output logic [7:0] mem_a,
  output logic [7:0] mem_b,
  output logic       out_valid,
  output logic [3:0] out_index,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, LOAD, SCAN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [4:0] len, len_in;
  logic [3:0] wr_ptr, rd_ptr, p_addr_a, p_addr_b;
  logic [7:0] p_a, p_b;
  logic hs, wr_last, rd_last, p_wr, p_rd, p_done, rd_q;
  assign len_in  = load_len > 5'd16 ? 5'd16 : load_len;
  assign hs      = state == LOAD && in_valid && in_ready;
  assign wr_last = {1'b0, wr_ptr} == len - 5'd1;
  assign rd_last = {1'b0, rd_ptr} == len - 5'd1;
  // next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? (len_in == 5'd0 ? DONE : LOAD) : IDLE;
      LOAD:    state_nx = hs && wr_last ? SCAN : LOAD;
      SCAN:    state_nx = rd_last ? DRAIN : SCAN;
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // run bookkeeping and the decided memory operation, staged one cycle ahead of the outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b0;
      p_wr     <= 1'b0;
      p_rd     <= 1'b0;
      p_done   <= 1'b0;
      p_addr_a <= '0;
      p_addr_b <= '0;
      p_a      <= '0;
      p_b      <= '0;
    end else begin
      p_wr     <= hs;
      p_rd     <= state == SCAN;
      p_done   <= state == DONE;
      in_ready <= state == LOAD && !(hs && wr_last);
      if (state == IDLE && start) begin
        len    <= len_in;
        wr_ptr <= '0;
      end
      if (hs) begin
        p_addr_a <= wr_ptr;
        p_addr_b <= wr_ptr;
        p_a      <= in_a;
        p_b      <= in_b;
        wr_ptr   <= wr_ptr + 4'd1;
        if (wr_last) rd_ptr <= '0;
      end
      if (state == SCAN) begin
        p_addr_a <= rd_ptr;
        p_addr_b <= len[3:0] - 4'd1 - rd_ptr;
        rd_ptr   <= rd_ptr + 4'd1;
      end
    end
  end
  // registered memory-side outputs plus read-return alignment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rw     <= 1'b0;
      mem_addr_a <= '0;
      mem_addr_b <= '0;
      mem_a      <= '0;
      mem_b      <= '0;
      rd_q       <= 1'b0;
      out_valid  <= 1'b0;
      out_index  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      mem_rw     <= p_wr;
      mem_addr_a <= p_addr_a;
      mem_addr_b <= p_addr_b;
      mem_a      <= p_a;
      mem_b      <= p_b;
      rd_q       <= p_rd;
      out_valid  <= rd_q;
      out_index  <= rd_q ? mem_addr_a : out_index;
      busy       <= state != IDLE || p_done;
      done       <= p_done;
    end
  end
endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: randomized runs against a timestamped transaction model of the sequencer
module tb_mem_sequencer;
  localparam int MAXC = 8192;
  logic clk = 0, reset = 0, start = 0, in_valid = 0;
  logic [4:0] load_len = 0;
  logic [7:0] in_a = 0, in_b = 0;
  logic in_ready, mem_rw, out_valid, busy, done;
  logic [3:0] mem_addr_a, mem_addr_b, out_index;
  logic [7:0] mem_a, mem_b;
  int checks = 0, failures = 0, cyc = 0;
  bit exp_ready [MAXC], exp_rw [MAXC], exp_rd [MAXC], exp_ov [MAXC], exp_done [MAXC], exp_busy [MAXC];
  bit [3:0] exp_wa [MAXC], exp_aa [MAXC], exp_ab [MAXC], exp_idx [MAXC];
  bit [7:0] exp_da [MAXC], exp_db [MAXC], exp_qa [MAXC], exp_qb [MAXC];
  bit loading = 0;
  int m_s = 0, m_n = 0, cnt = 0, free_at = 0;
  bit [7:0] ra [16], rb [16], pa [16], pb [16];
  logic [7:0] bank_a [16], bank_b [16], rq_a, rq_b;
  int done_cyc, busy_cnt, wr_cnt, ov_cnt;
  logic [7:0] obs_a [16], obs_b [16];

  always #5 clk = ~clk;

  mem_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .mem_rw(mem_rw), .mem_addr_a(mem_addr_a),
    .mem_addr_b(mem_addr_b), .mem_a(mem_a), .mem_b(mem_b), .out_valid(out_valid),
    .out_index(out_index), .busy(busy), .done(done)
  );

  // downstream memory stage: registered read, write committed at the edge
  always @(posedge clk) begin
    if (mem_rw) begin
      bank_a[mem_addr_a] <= mem_a;
      bank_b[mem_addr_b] <= mem_b;
    end
    rq_a <= bank_a[mem_addr_a];
    rq_b <= bank_b[mem_addr_b];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_mem_rw"}, mem_rw, 0);
    chk({tag, "_addr_a"}, mem_addr_a, 0);
    chk({tag, "_addr_b"}, mem_addr_b, 0);
    chk({tag, "_mem_a"}, mem_a, 0);
    chk({tag, "_mem_b"}, mem_b, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_index"}, out_index, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // per-cycle comparison against the model's timeline
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!reset && cyc < MAXC) begin
      chk("in_ready", in_ready, exp_ready[cyc]);
      chk("mem_rw", mem_rw, exp_rw[cyc]);
      chk("busy", busy, exp_busy[cyc]);
      chk("done", done, exp_done[cyc]);
      chk("out_valid", out_valid, exp_ov[cyc]);
      if (exp_rw[cyc]) begin
        chk("wr_addr_a", mem_addr_a, exp_wa[cyc]);
        chk("wr_addr_b", mem_addr_b, exp_wa[cyc]);
        chk("wr_data_a", mem_a, exp_da[cyc]);
        chk("wr_data_b", mem_b, exp_db[cyc]);
      end
      if (exp_rd[cyc]) begin
        chk("rd_addr_a", mem_addr_a, exp_aa[cyc]);
        chk("rd_addr_b", mem_addr_b, exp_ab[cyc]);
      end
      if (exp_ov[cyc]) begin
        chk("out_index", out_index, exp_idx[cyc]);
        chk("pair_a", rq_a, exp_qa[cyc]);
        chk("pair_b", rq_b, exp_qb[cyc]);
      end
      if (done) done_cyc = cyc;
      if (busy) busy_cnt++;
      if (mem_rw) wr_cnt++;
      if (out_valid) begin
        ov_cnt++;
        obs_a[out_index] = rq_a;
        obs_b[out_index] = rq_b;
      end
    end
  end

  task automatic clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      exp_ready[i] = 0; exp_rw[i] = 0; exp_rd[i] = 0; exp_ov[i] = 0; exp_done[i] = 0; exp_busy[i] = 0;
    end
  endtask

  // model the edge about to happen with the inputs now driven, then advance one cycle
  task automatic tick();
    int e;
    bit hs;
    e = cyc + 1;
    hs = loading && in_valid && exp_ready[cyc];
    if (!loading && e >= free_at && start) begin
      m_s = e;
      m_n = load_len > 16 ? 16 : int'(load_len);
      if (m_n == 0) begin
        exp_busy[e+1] = 1;
        exp_busy[e+2] = 1;
        exp_done[e+2] = 1;
        free_at = e + 2;
      end else begin
        loading = 1;
        cnt = 0;
        free_at = 1 << 30;
      end
    end
    if (hs) begin
      exp_rw[e+1] = 1;
      exp_wa[e+1] = cnt[3:0];
      exp_da[e+1] = in_a;
      exp_db[e+1] = in_b;
      ra[cnt] = in_a;
      rb[cnt] = in_b;
      cnt++;
      if (cnt == m_n) begin
        loading = 0;
        for (int i = 0; i < m_n; i++) begin
          exp_rd[e+2+i] = 1;
          exp_aa[e+2+i] = i[3:0];
          exp_ab[e+2+i] = 4'(m_n - 1 - i);
          exp_ov[e+3+i] = 1;
          exp_idx[e+3+i] = i[3:0];
          exp_qa[e+3+i] = ra[i];
          exp_qb[e+3+i] = rb[m_n-1-i];
        end
        exp_done[e+m_n+3] = 1;
        for (int c = e; c <= e + m_n + 3; c++) exp_busy[c] = 1;
        free_at = e + m_n + 3;
      end
    end
    if (loading && e >= m_s + 1) begin
      exp_ready[e] = 1;
      exp_busy[e] = 1;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      pa[i] = 8'($urandom);
      pb[i] = 8'($urandom);
    end
  endtask

  // mode 0: continuous in_valid; 1: random in_valid and stray start pulses; 2: two-cycle gap after first pair
  task automatic do_run(input int ll, input int mode);
    int g, t;
    g = 0;
    t = 0;
    done_cyc = -1; busy_cnt = 0; wr_cnt = 0; ov_cnt = 0;
    load_len = 5'(ll);
    start = 1;
    in_valid = 0;
    tick();
    start = 0;
    while (loading || cyc + 1 < free_at) begin
      if (t++ > 400) begin
        checks++;
        failures++;
        $display("FAIL run_timeout cyc=%0d got=busy exp=idle", cyc);
        break;
      end
      in_a = pa[cnt % 16];
      in_b = pb[cnt % 16];
      if (mode == 0) in_valid = 1;
      else if (mode == 1) begin
        in_valid = $urandom_range(0, 9) < 7;
        start = $urandom_range(0, 5) == 0;
        load_len = 5'($urandom);
      end else begin
        in_valid = !(cnt == 1 && g < 2);
        if (cnt == 1 && g < 2) g++;
      end
      tick();
    end
    start = 0;
    in_valid = 0;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

  initial begin
    #1 reset = 1;
    #1 chk_zero("por");
    repeat (2) @(posedge clk);
    #2 reset = 0;
    for (int i = 0; i < 16; i++) begin
      pa[i] = 8'((i + 1) * 10);
      pb[i] = 8'(i + 1);
    end
    do_run(4, 0);
    chk("len4_latency", done_cyc - m_s, 12);
    chk("len4_writes", wr_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      chk("len4_pair_a", obs_a[i], (i + 1) * 10);
      chk("len4_pair_b", obs_b[i], 4 - i);
    end
    fill_random();
    do_run(3, 2);
    chk("gap_latency", done_cyc - m_s, 12);
    chk("gap_writes", wr_cnt, 3);
    fill_random();
    do_run(20, 0);
    chk("clamp_writes", wr_cnt, 16);
    chk("clamp_reads", ov_cnt, 16);
    chk("clamp_latency", done_cyc - m_s, 36);
    chk("clamp_pair_a0", obs_a[0], pa[0]);
    chk("clamp_pair_b0", obs_b[0], pb[15]);
    do_run(0, 0);
    chk("zero_busy", busy_cnt, 2);
    chk("zero_writes", wr_cnt, 0);
    chk("zero_reads", ov_cnt, 0);
    chk("zero_latency", done_cyc - m_s, 2);
    fill_random();
    do_run(1, 0);
    chk("len1_latency", done_cyc - m_s, 6);
    chk("len1_pair_a", obs_a[0], pa[0]);
    chk("len1_pair_b", obs_b[0], pb[0]);
    fill_random();
    do_run(5, 1);
    chk("noisy_reads", ov_cnt, 5);
    fill_random();
    load_len = 8;
    start = 1;
    tick();
    start = 0;
    in_valid = 1;
    repeat (5) begin
      in_a = pa[cnt % 16];
      in_b = pb[cnt % 16];
      tick();
    end
    #1 reset = 1;
    #1 chk_zero("async_rst");
    clear_from(cyc + 1);
    loading = 0;
    free_at = 0;
    in_valid = 0;
    @(posedge clk);
    #2 reset = 0;
    fill_random();
    do_run(2, 0);
    chk("post_rst_latency", done_cyc - m_s, 8);
    for (int r = 0; r < 14 && cyc < MAXC - 200; r++) begin
      fill_random();
      do_run($urandom_range(0, 20), $urandom_range(0, 3) == 0 ? 0 : 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Upstream control stage for the dual-bank 16x8 memory stage. Accepts a run of 8-bit operand pairs over a valid/ready port and writes them to consecutive addresses. It then replays the stored run as reads, pairing bank A entry i with bank B entry (len-1-i), and flags when the memory stage's registered outputs hold each pair. All memory-side outputs are registered.

## Interface
Parameters:
- none (depth fixed at 16 entries, data width fixed at 8)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- load_len  in  5  number of pairs for the run; sampled with start
- in_valid  in  1  input pair valid
- in_ready  out  1  sequencer accepts a pair this cycle
- in_a, in_b  in  8 each  input pair data
- mem_rw  out  1  1 = write, 0 = read (to memory stage)
- mem_addr_a, mem_addr_b  out  4 each  memory addresses
- mem_a, mem_b  out  8 each  memory write data
- out_valid  out  1  memory stage outputs hold pair out_index this cycle
- out_index  out  4  index i of the pair currently presented
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run

## Operation
- States: IDLE, LOAD, SCAN, DRAIN, DONE.
- Reset values: state IDLE. in_ready, mem_rw, out_valid, busy and done are 0. mem_addr_a, mem_addr_b, mem_a, mem_b and out_index are 0. Internal len, wr_ptr and rd_ptr are 0.
- IDLE:
  - On start, latch len = min(load_len, 16).
  - len == 0 -> DONE, with no writes or reads.
  - Otherwise -> LOAD with wr_ptr = 0.
- LOAD:
  - in_ready = 1 (registered; high for every cycle spent in LOAD).
  - A handshake is in_valid & in_ready at a rising edge.
  - On a handshake, the next cycle presents mem_rw=1, mem_addr_a=mem_addr_b=wr_ptr, mem_a=in_a, mem_b=in_b. wr_ptr then increments.
  - With no handshake, mem_rw=0 and addresses and data hold.
  - Back-to-back handshakes produce back-to-back writes.
  - When the handshake with wr_ptr == len-1 occurs -> SCAN with rd_ptr = 0, and in_ready drops.
- SCAN:
  - Each cycle drives mem_rw=0, mem_addr_a=rd_ptr, mem_addr_b=len-1-rd_ptr, then increments rd_ptr.
  - The subtraction is 5-bit, truncated to 4 bits; the result is always in 0..15.
  - mem_a and mem_b hold their last values.
  - After issuing rd_ptr == len-1 -> DRAIN.
- out_valid/out_index:
  - out_valid is the read-issued flag delayed by one cycle.
  - out_index is rd_ptr delayed by one cycle.
  - This aligns with the memory stage's one-cycle registered read.
- DRAIN: mem_rw=0. Presents the final out_valid, then -> DONE.
- DONE: done=1 for one cycle, busy=0 next, -> IDLE.
- start outside IDLE: ignored. in_valid outside LOAD: ignored, no handshake.
- load_len > 16 is clamped to 16. A len of 16 writes addresses 0..15 with no wrap.
- Reset mid-run:
  - All outputs return to reset values immediately (asynchronously).
  - The partial run is abandoned and memory contents are not cleared by this block.

## Timing
- start accepted at edge k: in_ready = 1 from cycle k+1.
- Write latency: the handshake at edge h has mem_rw=1 with data during cycle h+1. The memory commits it at edge h+2.
- Read issue at cycle t: out_valid and out_index during cycle t+1.
- An uninterrupted run of len N takes 2N+4 cycles from start edge to done pulse, plus any in_valid stall cycles:
  - 1 cycle to enter LOAD
  - N handshakes
  - N reads
  - 1 DRAIN
  - 1 DONE
  - 1 cycle of the final write overlapping SCAN entry
- The first SCAN read follows the last write by one cycle. The memory commits that write at the edge that also samples the first read address. When len == 1 this is the same address, and read-after-write ordering through the memory stage must return the new data.

## Test plan
- Reset: assert reset mid-cycle with busy=1 -> all outputs 0 asynchronously, state IDLE, a following start works normally.
- len=4, pairs (a,b) = (10,1),(20,2),(30,3),(40,4), in_valid continuous -> writes at addresses 0..3, then out_index 0..3 shows a_out/b_out = (10,4),(20,3),(30,2),(40,1). done occurs 12 cycles after the start edge.
- len=3 with in_valid low for 2 cycles between pairs -> mem_rw=0 during gaps, addresses stay contiguous, done is delayed by exactly 2 cycles.
- load_len=20 -> clamped to 16: 16 writes, reads pair a[i] with b[15-i], wr_ptr never wraps.
- load_len=0 -> busy for 2 cycles, done pulses, no mem_rw=1, no out_valid.
- start and in_valid pulsed during SCAN -> ignored, scan sequence and out_index unchanged.
